// File: rtl/tdm_pkg.sv
// Shared constants and FIFO entry type for the TDM ingress multiplexer.
package tdm_pkg;

    localparam int unsigned NUM_QUEUES = 10;
    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned SLOT_W     = $clog2(NUM_QUEUES);

    typedef struct packed {
        logic                  sop;
        logic [DATA_WIDTH-1:0] data;
    } tdm_entry_t;

endpackage

// File: rtl/tdm_port_fifo.sv
// Per-port synchronous FIFO holding {sop, data} entries; registered head, no fall-through.
module tdm_port_fifo
    import tdm_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_i,
    input  tdm_entry_t wdata_i,
    input  logic       pop_i,
    output tdm_entry_t rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    tdm_entry_t      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/tdm_ingress_mux.sv
// Buffers per-port byte streams and serialises them onto one TDM lane, one slot per port.
module tdm_ingress_mux #(
    parameter int unsigned NUM_QUEUES = tdm_pkg::NUM_QUEUES,
    parameter int unsigned DATA_WIDTH = tdm_pkg::DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH = tdm_pkg::FIFO_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic [NUM_QUEUES-1:0]            port_valid,
    input  logic [NUM_QUEUES-1:0]            port_sop,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] port_data,
    output logic [NUM_QUEUES-1:0]            port_ready,
    output logic                             tx_valid,
    output logic                             tx_new_packet,
    output logic [DATA_WIDTH-1:0]            tx_data,
    output logic [$clog2(NUM_QUEUES)-1:0]    tx_slot,
    output logic                             tx_frame_start
);

    import tdm_pkg::tdm_entry_t;

    localparam int unsigned SlotW = $clog2(NUM_QUEUES);

    logic [SlotW-1:0]      slot_q, slot_d;
    logic [NUM_QUEUES-1:0] full, empty, pop;
    tdm_entry_t            wdata [NUM_QUEUES];
    tdm_entry_t            head  [NUM_QUEUES];
    tdm_entry_t            sel_entry;
    logic                  sel_empty;

    logic                  tx_valid_d, tx_new_packet_d, tx_frame_start_d;
    logic [DATA_WIDTH-1:0] tx_data_d;
    logic [SlotW-1:0]      tx_slot_d;

    for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_port
        assign wdata[i] = '{sop: port_sop[i], data: port_data[i*DATA_WIDTH +: DATA_WIDTH]};
        assign pop[i]   = en && (slot_q == SlotW'(i));

        tdm_port_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (port_valid[i]),
            .wdata_i (wdata[i]),
            .pop_i   (pop[i]),
            .rdata_o (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );
    end

    assign port_ready = ~full;

    always_comb begin
        sel_entry = '0;
        sel_empty = 1'b1;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (slot_q == SlotW'(i)) begin
                sel_entry = head[i];
                sel_empty = empty[i];
            end
        end
    end

    // en low yields an idle beat and freezes the slot position.
    always_comb begin
        slot_d           = slot_q;
        tx_valid_d       = 1'b0;
        tx_new_packet_d  = 1'b0;
        tx_data_d        = '0;
        tx_slot_d        = tx_slot;
        tx_frame_start_d = 1'b0;
        if (en) begin
            slot_d           = (slot_q == SlotW'(NUM_QUEUES - 1)) ? '0 : slot_q + SlotW'(1);
            tx_valid_d       = !sel_empty;
            tx_new_packet_d  = !sel_empty && sel_entry.sop;
            tx_data_d        = sel_empty ? '0 : sel_entry.data;
            tx_slot_d        = slot_q;
            tx_frame_start_d = (slot_q == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q         <= '0;
            tx_valid       <= 1'b0;
            tx_new_packet  <= 1'b0;
            tx_data        <= '0;
            tx_slot        <= '0;
            tx_frame_start <= 1'b0;
        end else begin
            slot_q         <= slot_d;
            tx_valid       <= tx_valid_d;
            tx_new_packet  <= tx_new_packet_d;
            tx_data        <= tx_data_d;
            tx_slot        <= tx_slot_d;
            tx_frame_start <= tx_frame_start_d;
        end
    end

endmodule

// File: tb/tb_tdm_ingress_mux.sv
// Randomised and directed bench for tdm_ingress_mux against a queue-based reference model.
module tb_tdm_ingress_mux;

    localparam int NQ    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en  = 1'b0;
    logic [NQ-1:0]    pv  = '0;
    logic [NQ-1:0]    ps  = '0;
    logic [NQ*DW-1:0] pd  = '0;
    logic [NQ-1:0]    port_ready;
    logic             tx_valid, tx_new_packet, tx_frame_start;
    logic [DW-1:0]    tx_data;
    logic [3:0]       tx_slot;

    tdm_ingress_mux dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .port_valid     (pv),
        .port_sop       (ps),
        .port_data      (pd),
        .port_ready     (port_ready),
        .tx_valid       (tx_valid),
        .tx_new_packet  (tx_new_packet),
        .tx_data        (tx_data),
        .tx_slot        (tx_slot),
        .tx_frame_start (tx_frame_start)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: per-port circular byte stores plus a frame position.
    logic [8:0]  mmem [NQ][64];
    int          mhd [NQ];
    int          mtl [NQ];
    int          m_slot = 0;
    logic        m_valid, m_sop, m_fs;
    logic [7:0]  m_data;
    int          m_tx_slot;

    int          watch = -1;
    logic [8:0]  cap [$];
    int          idle_beats;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_edge();
        logic [NQ-1:0] can;
        if (rst) begin
            for (int i = 0; i < NQ; i++) begin
                mhd[i] = 0;
                mtl[i] = 0;
            end
            m_slot = 0; m_valid = 0; m_sop = 0; m_data = 0; m_tx_slot = 0; m_fs = 0;
        end else begin
            for (int i = 0; i < NQ; i++) can[i] = (mtl[i] - mhd[i]) < DEPTH;
            if (en) begin
                if (mtl[m_slot] != mhd[m_slot]) begin
                    {m_sop, m_data} = mmem[m_slot][mhd[m_slot] % 64];
                    m_valid = 1;
                    mhd[m_slot]++;
                end else begin
                    m_valid = 0; m_sop = 0; m_data = 0;
                end
                m_tx_slot = m_slot;
                m_fs      = (m_slot == 0);
                m_slot    = (m_slot + 1) % NQ;
            end else begin
                m_valid = 0; m_sop = 0; m_data = 0; m_fs = 0;
            end
            for (int i = 0; i < NQ; i++) begin
                if (pv[i] && can[i]) begin
                    mmem[i][mtl[i] % 64] = {ps[i], pd[i*DW +: DW]};
                    mtl[i]++;
                end
            end
        end
    endtask

    task automatic cycle();
        logic [NQ-1:0] rdy;
        model_edge();
        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++) rdy[i] = (mtl[i] - mhd[i]) < DEPTH;
        chk("tx_valid", 32'(tx_valid), 32'(m_valid));
        chk("tx_new_packet", 32'(tx_new_packet), 32'(m_sop));
        chk("tx_data", 32'(tx_data), 32'(m_data));
        chk("tx_slot", 32'(tx_slot), 32'(m_tx_slot));
        chk("tx_frame_start", 32'(tx_frame_start), 32'(m_fs));
        chk("port_ready", 32'(port_ready), 32'(rdy));
        if (watch >= 0 && tx_valid === 1'b1 && int'(tx_slot) == watch)
            cap.push_back({tx_new_packet, tx_data});
    endtask

    task automatic do_reset();
        rst = 1; en = 0; pv = '0; ps = '0;
        cycle();
        rst = 0;
    endtask

    task automatic push1(int p, logic sop, logic [7:0] d);
        pv = '0; ps = '0;
        pv[p] = 1'b1;
        ps[p] = sop;
        pd[p*DW +: DW] = d;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_slot", 32'(tx_slot), 0);
        chk("rst_ready", 32'(port_ready), 32'h3FF);

        // Idle frames: slot sequence and frame marker
        en = 1;
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("idle_valid", 32'(tx_valid), 0);
            chk("idle_slot", 32'(tx_slot), 32'(k % 10));
            chk("idle_fs", 32'(tx_frame_start), 32'(k % 10 == 0));
        end

        // Two bytes through port 3
        do_reset();
        en = 1; watch = 3; cap.delete();
        push1(3, 1'b1, 8'hA5); cycle();
        push1(3, 1'b0, 8'h5A); cycle();
        pv = '0;
        for (int k = 0; k < 25; k++) cycle();
        chk("p3_count", 32'(cap.size()), 2);
        if (cap.size() == 2) begin
            chk("p3_first", 32'(cap[0]), 32'h1A5);
            chk("p3_second", 32'(cap[1]), 32'h05A);
        end

        // Fill port 7 while frozen, then drain
        do_reset();
        for (int k = 0; k < 16; k++) begin
            push1(7, k == 0, 8'(8'h10 + k));
            cycle();
        end
        chk("p7_full_ready", 32'(port_ready[7]), 0);
        push1(7, 1'b0, 8'hEE);
        cycle();
        chk("p7_still_full", 32'(port_ready[7]), 0);
        pv = '0; en = 1; watch = 7; cap.delete();
        for (int k = 0; k < 170; k++) cycle();
        chk("p7_count", 32'(cap.size()), 16);
        for (int k = 0; k < 16 && k < cap.size(); k++)
            chk("p7_byte", 32'(cap[k]), 32'({k == 0, 8'(8'h10 + k)}));

        // Every port streaming at one byte per frame
        do_reset();
        en = 1; watch = -1; idle_beats = 0;
        for (int k = 0; k < 200; k++) begin
            push1(m_slot, $urandom_range(0, 1) == 1, 8'($urandom));
            cycle();
            if (k >= 10 && tx_valid !== 1'b1) idle_beats++;
        end
        chk("stream_idle_beats", 32'(idle_beats), 0);
        chk("stream_ready", 32'(port_ready), 32'h3FF);
        pv = '0;

        // Reset while port 2 holds bytes
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push1(2, k == 0, 8'(8'h30 + k));
            cycle();
        end
        rst = 1; push1(2, 1'b1, 8'h77);
        cycle();
        rst = 0; pv = '0;
        chk("rst2_ready", 32'(port_ready), 32'h3FF);
        chk("rst2_valid", 32'(tx_valid), 0);
        en = 1; watch = 2; cap.delete();
        for (int k = 0; k < 30; k++) cycle();
        chk("rst2_stale", 32'(cap.size()), 0);

        // Enable pause at slot 4
        do_reset();
        watch = -1;
        for (int p = 0; p < NQ; p++) begin
            push1(p, 1'b1, 8'(p));
            cycle();
        end
        pv = '0; en = 1;
        for (int k = 0; k < 20 && tx_slot != 4'd4; k++) cycle();
        chk("pause_reach4", 32'(tx_slot), 4);
        en = 0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("pause_hold", 32'(tx_slot), 4);
            chk("pause_fs", 32'(tx_frame_start), 0);
        end
        en = 1;
        cycle();
        chk("pause_resume", 32'(tx_slot), 5);
        for (int k = 0; k < 30; k++) cycle();

        // Random traffic
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 9) != 0);
            for (int p = 0; p < NQ; p++) begin
                pv[p] = ($urandom_range(0, 2) == 0);
                ps[p] = ($urandom_range(0, 3) == 0);
                pd[p*DW +: DW] = 8'($urandom);
            end
            cycle();
        end
        rst = 0; pv = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
